// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, FSM states and baud divider helpers
// Shared by the transmitter and its future receiver counterpart.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_t;

  function automatic int calcDiv(input int clkFreq, input int baud, input int simFast);
    if (simFast != 0) return 1;
    if (baud <= 0) return 0;
    return clkFreq / baud;
  endfunction

  // A real line needs at least two clocks per bit; fast-sim mode is exempt.
  function automatic bit divLegal(input int clkFreq, input int baud, input int simFast);
    return (simFast != 0) || (calcDiv(clkFreq, baud, simFast) >= 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised RS-232 transmitter with input FIFO
// TxD is registered from the current FSM state, so the line trails the state by one clock.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SIM_FAST   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tx_valid,
  input  logic [DATA_W-1:0]              tx_data,
  output logic                           tx_ready,
  input  logic [1:0]                     parity_mode,
  output logic                           TxD,
  output logic                           tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int DIV   = calcDiv(CLK_FREQ, BAUD, SIM_FAST);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (!divLegal(CLK_FREQ, BAUD, SIM_FAST) || DATA_W < 5 || DATA_W > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
    $error("uart_tx_fifo: illegal parameter combination");
  end

  txState_t          state;
  logic [CNT_W-1:0]  baudCnt;
  logic [3:0]        bitIdx;
  logic [DATA_W-1:0] shiftReg;
  logic              parityOn;
  logic              parityBit;
  logic [DATA_W-1:0] fifoDout;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              bitEnd;
  logic              frameDone;
  logic              pop;
  logic              lineBit;

  assign bitEnd    = (state != ST_IDLE) && (baudCnt == CNT_LAST);
  assign frameDone = (state == ST_STOP) && bitEnd && (bitIdx == STOP_LAST);
  // Popping at the last stop clock lets back-to-back frames run with no idle gap.
  assign pop       = !fifoEmpty && ((state == ST_IDLE) || frameDone);
  assign tx_ready  = !fifoFull || pop;
  assign tx_busy   = (state != ST_IDLE) || (fifo_count != '0);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_count)
  );

  always_comb begin
    lineBit = 1'b1;
    case (state)
      ST_START:  lineBit = 1'b0;
      ST_DATA:   lineBit = shiftReg[0];
      ST_PARITY: lineBit = parityBit;
      default:   lineBit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityOn  <= 1'b0;
      parityBit <= 1'b0;
      TxD       <= 1'b1;
    end else begin
      TxD <= lineBit;
      if (pop) begin
        state     <= ST_START;
        baudCnt   <= '0;
        bitIdx    <= '0;
        shiftReg  <= fifoDout;
        parityOn  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        parityBit <= (^fifoDout) ^ (parity_mode == PAR_ODD);
      end else begin
        if (state != ST_IDLE) baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
        if (bitEnd) begin
          case (state)
            ST_START: begin
              state  <= ST_DATA;
              bitIdx <= '0;
            end
            ST_DATA: begin
              shiftReg <= shiftReg >> 1;
              if (bitIdx == DATA_LAST) begin
                bitIdx <= '0;
                state  <= parityOn ? ST_PARITY : ST_STOP;
              end else begin
                bitIdx <= bitIdx + 1'b1;
              end
            end
            ST_PARITY: begin
              state  <= ST_STOP;
              bitIdx <= '0;
            end
            ST_STOP: begin
              if (bitIdx == STOP_LAST) begin
                state  <= ST_IDLE;
                bitIdx <= '0;
              end else begin
                bitIdx <= bitIdx + 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
